framebuffer_row_fetch: RTL and testbench

- Read-side engine for the 16-bit port of the dual-port framebuffer RAM.
- On a start request it fetches one full display row: RAM_COLS consecutive 16-bit words at word address {row, column}.
- Words are streamed to the panel shift logic over a valid/ready interface.
- A small credit-limited output FIFO absorbs the RAM read latency, so backpressure never drops or duplicates a word.

---
 rtl/framebuffer_row_fetch_if.sv | 26 ++
 rtl/framebuffer_row_fetch.sv | 151 +++++++++++++++
 tb/tb_framebuffer_row_fetch.sv | 358 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/framebuffer_row_fetch_if.sv
// RAM read-port and pixel-stream signals of the framebuffer row fetch engine.
// master = fetch engine, slave = RAM port plus panel shift logic.
interface framebuffer_row_fetch_if #(
  parameter int ROW_BITS   = 5,
  parameter int COL_BITS   = 6,
  parameter int DATA_WIDTH = 16
);
  logic [ROW_BITS+COL_BITS-1:0] ram_addr;
  logic                         ram_clk_en;
  logic [DATA_WIDTH-1:0]        ram_data;
  logic [DATA_WIDTH-1:0]        pix_data;
  logic [COL_BITS-1:0]          pix_col;
  logic                         pix_last;
  logic                         pix_valid;
  logic                         pix_ready;

  modport master (
    output ram_addr, ram_clk_en, pix_data, pix_col, pix_last, pix_valid,
    input  ram_data, pix_ready
  );

  modport slave (
    input  ram_addr, ram_clk_en, pix_data, pix_col, pix_last, pix_valid,
    output ram_data, pix_ready
  );
endinterface

// File: rtl/framebuffer_row_fetch.sv
// Fetches one framebuffer row from the RAM read port and streams it out
// through a credit-limited FIFO that absorbs the RAM read latency.
module framebuffer_row_fetch #(
  parameter int ROW_BITS   = 5,
  parameter int COL_BITS   = 6,
  parameter int DATA_WIDTH = 16,
  parameter int RD_LATENCY = 1,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                    clk_root,
  input  logic                    reset,
  input  logic                    start,
  input  logic [ROW_BITS-1:0]     row,
  output logic                    busy,
  output logic                    done,
  framebuffer_row_fetch_if.master bus
);
  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 2;
  localparam logic [COL_BITS-1:0] LAST_COL = '1;
  localparam logic [COL_BITS-1:0] COL_ONE  = 1;
  localparam logic [PTR_W-1:0]    PTR_ONE  = 1;
  localparam logic [PTR_W:0]      OCC_ONE  = 1;
  localparam logic [CNT_W-1:0]    DEPTH_C  = FIFO_DEPTH;

  typedef enum logic [1:0] {IDLE, FETCH, DRAIN, DONE} state_t;

  state_t                       state, state_next;
  logic [ROW_BITS-1:0]          row_q;
  logic [ROW_BITS-1:0]          issue_row;
  logic [COL_BITS-1:0]          issue_col, issue_col_next, issue_sel;
  logic                         issue;
  logic [ROW_BITS+COL_BITS-1:0] ram_addr_q;

  logic [RD_LATENCY:0]          vld_sr;
  logic [COL_BITS-1:0]          col_sr [RD_LATENCY+1];

  logic [DATA_WIDTH-1:0]        data_mem [FIFO_DEPTH];
  logic [COL_BITS-1:0]          col_mem  [FIFO_DEPTH];
  logic [PTR_W-1:0]             wr_ptr, rd_ptr;
  logic [PTR_W:0]               count;
  logic [CNT_W-1:0]             inflight;
  logic                         credit_ok, wr_en, rd_en, head_valid, last_xfer;
  logic [COL_BITS-1:0]          head_col;

  // Stage 0 of vld_sr is the issue register itself, so every outstanding
  // read is counted from the cycle ram_clk_en goes high until it lands.
  always_comb begin
    inflight = '0;
    for (int i = 0; i <= RD_LATENCY; i++) begin
      inflight = inflight + CNT_W'(vld_sr[i]);
    end
  end

  assign credit_ok  = (CNT_W'(count) + inflight) < DEPTH_C;
  assign wr_en      = vld_sr[RD_LATENCY];
  assign head_valid = (count != '0);
  assign head_col   = col_mem[rd_ptr];
  assign rd_en      = head_valid && bus.pix_ready;
  assign last_xfer  = rd_en && (head_col == LAST_COL);

  // Column 0 is issued on the accepting edge so a row takes 2^COL_BITS+RD_LATENCY+2 cycles.
  always_comb begin
    state_next     = state;
    issue          = 1'b0;
    issue_row      = row_q;
    issue_sel      = issue_col;
    issue_col_next = issue_col;
    unique case (state)
      IDLE: begin
        if (start) begin
          issue          = 1'b1;
          issue_row      = row;
          issue_sel      = '0;
          issue_col_next = COL_ONE;
          state_next     = FETCH;
        end
      end
      FETCH: begin
        if (credit_ok) begin
          issue          = 1'b1;
          issue_col_next = issue_col + COL_ONE;
          if (issue_col == LAST_COL) state_next = DRAIN;
        end
      end
      DRAIN: begin
        if (last_xfer) state_next = DONE;
      end
      DONE: state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk_root) begin
    if (reset) begin
      state      <= IDLE;
      row_q      <= '0;
      issue_col  <= '0;
      ram_addr_q <= '0;
    end else begin
      state     <= state_next;
      issue_col <= issue_col_next;
      if (state == IDLE && start) row_q <= row;
      if (issue) ram_addr_q <= {issue_row, issue_sel};
    end
  end

  // Clearing vld_sr on reset discards any read still returning from the RAM.
  always_ff @(posedge clk_root) begin
    if (reset) begin
      vld_sr <= '0;
      for (int i = 0; i <= RD_LATENCY; i++) col_sr[i] <= '0;
    end else begin
      vld_sr    <= {vld_sr[RD_LATENCY-1:0], issue};
      col_sr[0] <= issue_sel;
      for (int i = 1; i <= RD_LATENCY; i++) col_sr[i] <= col_sr[i-1];
    end
  end

  always_ff @(posedge clk_root) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (wr_en) wr_ptr <= wr_ptr + PTR_ONE;
      if (rd_en) rd_ptr <= rd_ptr + PTR_ONE;
      unique case ({wr_en, rd_en})
        2'b10:   count <= count + OCC_ONE;
        2'b01:   count <= count - OCC_ONE;
        default: count <= count;
      endcase
    end
  end

  always_ff @(posedge clk_root) begin
    if (wr_en) begin
      data_mem[wr_ptr] <= bus.ram_data;
      col_mem[wr_ptr]  <= col_sr[RD_LATENCY];
    end
  end

  assign bus.ram_addr   = ram_addr_q;
  assign bus.ram_clk_en = vld_sr[0];
  assign bus.pix_valid  = head_valid;
  assign bus.pix_data   = head_valid ? data_mem[rd_ptr] : '0;
  assign bus.pix_col    = head_valid ? head_col : '0;
  assign bus.pix_last   = head_valid && (head_col == LAST_COL);
  assign busy           = (state == FETCH) || (state == DRAIN);
  assign done           = (state == DONE);
endmodule

// File: tb/tb_framebuffer_row_fetch.sv
// Directed bench for framebuffer_row_fetch: one RD_LATENCY=1/FIFO_DEPTH=4
// instance and one RD_LATENCY=3/FIFO_DEPTH=8 instance, each with a RAM model.
module tb_framebuffer_row_fetch;
  logic        clk_root = 1'b0;
  logic        reset;
  logic        a_start, b_start;
  logic [4:0]  a_row, b_row;
  logic        a_busy, a_done, b_busy, b_done;
  logic        a_ready, b_ready;
  logic [15:0] a_ram_q, b_ram_q;
  logic        ready_rand;
  int          cyc;
  int          checks, failures;

  logic [22:0] a_xfer_q[$];
  int          a_issued, a_xfers, a_max_out, a_stab_err;
  int          a_done_cnt, a_done_cyc, a_first_valid, a_start_cyc;
  logic        a_hold;
  logic [23:0] a_prev;

  logic [22:0] b_xfer_q[$];
  logic [10:0] b_addr_q[$];
  int          b_done_cnt, b_done_cyc;

  framebuffer_row_fetch_if #(.ROW_BITS(5), .COL_BITS(6), .DATA_WIDTH(16)) a_if ();
  framebuffer_row_fetch_if #(.ROW_BITS(5), .COL_BITS(6), .DATA_WIDTH(16)) b_if ();

  assign a_if.pix_ready = a_ready;
  assign a_if.ram_data  = a_ram_q;
  assign b_if.pix_ready = b_ready;
  assign b_if.ram_data  = b_ram_q;

  framebuffer_row_fetch #(
    .ROW_BITS(5), .COL_BITS(6), .DATA_WIDTH(16), .RD_LATENCY(1), .FIFO_DEPTH(4)
  ) dut_a (
    .clk_root(clk_root), .reset(reset), .start(a_start), .row(a_row),
    .busy(a_busy), .done(a_done), .bus(a_if)
  );

  framebuffer_row_fetch #(
    .ROW_BITS(5), .COL_BITS(6), .DATA_WIDTH(16), .RD_LATENCY(3), .FIFO_DEPTH(8)
  ) dut_b (
    .clk_root(clk_root), .reset(reset), .start(b_start), .row(b_row),
    .busy(b_busy), .done(b_done), .bus(b_if)
  );

  always #5 clk_root = ~clk_root;

  initial begin
    cyc = 0;
    forever begin
      @(posedge clk_root);
      cyc++;
    end
  end

  function automatic logic [15:0] ramWord(input logic [10:0] addr);
    return {5'b0, addr} ^ 16'hA5A5;
  endfunction

  function automatic logic [22:0] expWord(input logic [4:0] r, input logic [5:0] c);
    return {c == 6'd63, c, ramWord({r, c})};
  endfunction

  // RAM models: data for an issue in cycle T is presented in cycle T+latency.
  initial begin
    logic        cap_en;
    logic [10:0] cap_addr;
    a_ram_q = 16'hDEAD;
    forever begin
      @(negedge clk_root);
      cap_en   = a_if.ram_clk_en;
      cap_addr = a_if.ram_addr;
      @(posedge clk_root);
      #1;
      a_ram_q = cap_en ? ramWord(cap_addr) : 16'hDEAD;
    end
  end

  initial begin
    logic        cap_en;
    logic [10:0] cap_addr;
    logic [15:0] pipe [3];
    for (int i = 0; i < 3; i++) pipe[i] = 16'hDEAD;
    b_ram_q = 16'hDEAD;
    forever begin
      @(negedge clk_root);
      cap_en   = b_if.ram_clk_en;
      cap_addr = b_if.ram_addr;
      @(posedge clk_root);
      #1;
      pipe[2] = pipe[1];
      pipe[1] = pipe[0];
      pipe[0] = cap_en ? ramWord(cap_addr) : 16'hDEAD;
      b_ram_q = pipe[2];
    end
  end

  // Backpressure: pseudo-random ready with a 10-cycle low window mid-row.
  initial begin
    logic [7:0] lfsr;
    lfsr    = 8'hB5;
    a_ready = 1'b1;
    forever begin
      @(posedge clk_root);
      #1;
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      if (!ready_rand) a_ready = 1'b1;
      else if (cyc >= a_start_cyc + 30 && cyc < a_start_cyc + 40) a_ready = 1'b0;
      else a_ready = lfsr[0];
    end
  end

  always @(negedge clk_root) begin
    if (reset) begin
      a_issued = 0;
      a_xfers  = 0;
      a_hold   = 1'b0;
    end else begin
      if (a_if.ram_clk_en) a_issued++;
      if (a_issued - a_xfers > a_max_out) a_max_out = a_issued - a_xfers;
      if (a_hold && {a_if.pix_valid, a_if.pix_last, a_if.pix_col, a_if.pix_data} != a_prev)
        a_stab_err++;
      a_hold = a_if.pix_valid && !a_ready;
      a_prev = {a_if.pix_valid, a_if.pix_last, a_if.pix_col, a_if.pix_data};
      if (a_if.pix_valid && a_first_valid < 0) a_first_valid = cyc;
      if (a_if.pix_valid && a_ready) begin
        a_xfer_q.push_back({a_if.pix_last, a_if.pix_col, a_if.pix_data});
        a_xfers++;
      end
      if (a_done) begin
        a_done_cnt++;
        a_done_cyc = cyc;
      end
    end
  end

  always @(negedge clk_root) begin
    if (!reset) begin
      if (b_if.ram_clk_en) b_addr_q.push_back(b_if.ram_addr);
      if (b_if.pix_valid && b_ready)
        b_xfer_q.push_back({b_if.pix_last, b_if.pix_col, b_if.pix_data});
      if (b_done) begin
        b_done_cnt++;
        b_done_cyc = cyc;
      end
    end
  end

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s observed=0x%0h expected=0x%0h", tag, observed, expected);
    end
  endtask

  task automatic clearA();
    a_xfer_q.delete();
    a_max_out     = 0;
    a_stab_err    = 0;
    a_done_cnt    = 0;
    a_done_cyc    = 0;
    a_first_valid = -1;
  endtask

  // Called at posedge+1; start is then sampled on the following edge.
  task automatic applyStimulus(input logic [4:0] r, input bit record);
    a_start = 1'b1;
    a_row   = r;
    if (record) a_start_cyc = cyc;
    @(posedge clk_root);
    #1;
    a_start = 1'b0;
  endtask

  task automatic waitCycle(input int target);
    int n = 0;
    while (cyc < target && n < 1000) begin
      @(posedge clk_root);
      #1;
      n++;
    end
  endtask

  task automatic waitDone(input int target, input int budget, input string tag);
    int n = 0;
    while (a_done_cnt < target && n < budget) begin
      @(posedge clk_root);
      #1;
      n++;
    end
    checkOutput(tag, a_done_cnt >= target, 1);
  endtask

  task automatic verifyRow(input string tag, input bit sel_b, input int base, input logic [4:0] r);
    logic [22:0] got;
    for (int i = 0; i < 64; i++) begin
      if (!sel_b) got = (base + i < a_xfer_q.size()) ? a_xfer_q[base + i] : '1;
      else        got = (base + i < b_xfer_q.size()) ? b_xfer_q[base + i] : '1;
      checkOutput($sformatf("%s w%0d", tag, i), 32'(got), 32'(expWord(r, 6'(i))));
    end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int s, n, vcnt;
    checks = 0; failures = 0;
    reset = 1'b1; a_start = 1'b0; b_start = 1'b0; a_row = '0; b_row = '0;
    b_ready = 1'b1; ready_rand = 1'b0; a_start_cyc = 0;
    b_done_cnt = 0; b_done_cyc = 0;
    clearA();

    repeat (3) @(posedge clk_root);
    @(negedge clk_root);
    checkOutput("rst busy",      a_busy, 0);
    checkOutput("rst done",      a_done, 0);
    checkOutput("rst ram_clk_en", a_if.ram_clk_en, 0);
    checkOutput("rst ram_addr",  a_if.ram_addr, 0);
    checkOutput("rst pix_valid", a_if.pix_valid, 0);
    checkOutput("rst pix_last",  a_if.pix_last, 0);
    checkOutput("rst pix_data",  a_if.pix_data, 0);
    checkOutput("rst pix_col",   a_if.pix_col, 0);
    checkOutput("rst b busy",    b_busy, 0);
    @(posedge clk_root);
    #1;
    reset = 1'b0;
    repeat (2) @(posedge clk_root);
    #1;

    $display("[TB] row 3, ready high");
    clearA();
    applyStimulus(5'd3, 1'b1);
    waitDone(1, 300, "r3 done seen");
    verifyRow("r3", 1'b0, 0, 5'd3);
    checkOutput("r3 count",   a_xfer_q.size(), 64);
    checkOutput("r3 latency", a_done_cyc - a_start_cyc, 67);
    checkOutput("r3 credits", a_max_out <= 4, 1);
    repeat (2) @(posedge clk_root);
    #1;

    $display("[TB] row 3, backpressure");
    clearA();
    ready_rand = 1'b1;
    applyStimulus(5'd3, 1'b1);
    waitDone(1, 1000, "r3bp done seen");
    repeat (3) @(posedge clk_root);
    #1;
    ready_rand = 1'b0;
    verifyRow("r3bp", 1'b0, 0, 5'd3);
    checkOutput("r3bp count",     a_xfer_q.size(), 64);
    checkOutput("r3bp credits",   a_max_out <= 4, 1);
    checkOutput("r3bp stability", a_stab_err, 0);
    checkOutput("r3bp done pulses", a_done_cnt, 1);
    repeat (2) @(posedge clk_root);
    #1;

    $display("[TB] starts while busy and in DONE");
    clearA();
    applyStimulus(5'd5, 1'b1);
    s = a_start_cyc;
    waitCycle(s + 10);
    applyStimulus(5'd9, 1'b0);
    waitCycle(s + 67);
    applyStimulus(5'd9, 1'b0);
    repeat (3) @(posedge clk_root);
    #1;
    checkOutput("ign busy",        a_busy, 0);
    checkOutput("ign done pulses", a_done_cnt, 1);
    checkOutput("ign latency",     a_done_cyc - s, 67);
    checkOutput("ign count",       a_xfer_q.size(), 64);
    verifyRow("ign r5", 1'b0, 0, 5'd5);

    $display("[TB] back-to-back rows 0 and 1");
    clearA();
    applyStimulus(5'd0, 1'b1);
    s = a_start_cyc;
    waitCycle(s + 68);
    applyStimulus(5'd1, 1'b1);
    waitDone(2, 400, "b2b done seen");
    checkOutput("b2b count",       a_xfer_q.size(), 128);
    checkOutput("b2b done pulses", a_done_cnt, 2);
    checkOutput("b2b latency r1",  a_done_cyc - a_start_cyc, 67);
    verifyRow("b2b r0", 1'b0, 0,  5'd0);
    verifyRow("b2b r1", 1'b0, 64, 5'd1);
    repeat (2) @(posedge clk_root);
    #1;

    $display("[TB] reset mid-row 7, then row 8");
    clearA();
    applyStimulus(5'd7, 1'b1);
    n = 0;
    while (a_xfer_q.size() < 20 && n < 200) begin
      @(posedge clk_root);
      #1;
      n++;
    end
    checkOutput("r7 reached word 20", a_xfer_q.size() >= 20, 1);
    reset = 1'b1;
    @(posedge clk_root);
    #1;
    reset = 1'b0;
    @(negedge clk_root);
    checkOutput("abort busy",      a_busy, 0);
    checkOutput("abort pix_valid", a_if.pix_valid, 0);
    vcnt = 0;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk_root);
      if (a_if.pix_valid) vcnt++;
    end
    checkOutput("abort stale valid", vcnt, 0);
    @(posedge clk_root);
    #1;
    clearA();
    applyStimulus(5'd8, 1'b1);
    waitDone(1, 300, "r8 done seen");
    checkOutput("r8 first valid", a_first_valid - a_start_cyc, 3);
    checkOutput("r8 count", a_xfer_q.size(), 64);
    verifyRow("r8", 1'b0, 0, 5'd8);
    repeat (2) @(posedge clk_root);
    #1;

    $display("[TB] RD_LATENCY=3 instance, row 31");
    b_xfer_q.delete();
    b_addr_q.delete();
    b_done_cnt = 0;
    b_start = 1'b1;
    b_row   = 5'd31;
    s       = cyc;
    @(posedge clk_root);
    #1;
    b_start = 1'b0;
    n = 0;
    while (b_done_cnt < 1 && n < 400) begin
      @(posedge clk_root);
      #1;
      n++;
    end
    checkOutput("l3 done seen",   b_done_cnt >= 1, 1);
    checkOutput("l3 latency",     b_done_cyc - s, 69);
    checkOutput("l3 issue count", b_addr_q.size(), 64);
    checkOutput("l3 count",       b_xfer_q.size(), 64);
    for (int i = 0; i < 64; i++) begin
      checkOutput($sformatf("l3 addr %0d", i),
                  (i < b_addr_q.size()) ? 32'(b_addr_q[i]) : 32'hFFFF_FFFF, 32'h7C0 + i);
    end
    verifyRow("l3 r31", 1'b1, 0, 5'd31);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
